// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG crank wheel generator.
package hwag_pkg;

    typedef enum logic [1:0] {
        CWG_IDLE,
        CWG_HIGH,
        CWG_LOW,
        CWG_GAP
    } cwg_state_t;

    localparam int unsigned CWG_MIN_PERIOD = 2;

endpackage

// File: rtl/crank_tooth_timer.sv
// Phase timer: loading N makes o_done assert N cycles later; shared by every wheel phase.
module crank_tooth_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_load_val,
    output logic                o_done
);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PERIOD_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/crank_wheel_gen.sv
// Synthetic N-M crank trigger wheel generator with shadowed period and teeth configuration.
module crank_wheel_gen
    import hwag_pkg::*;
#(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned TEETH_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                period_we,
    input  logic [PERIOD_W-1:0] period_d,
    input  logic                teeth_we,
    input  logic [TEETH_W-1:0]  teeth_total_d,
    input  logic [TEETH_W-1:0]  gap_teeth_d,
    output logic                vr_out,
    output logic                tooth_edge,
    output logic                rev_sync,
    output logic [TEETH_W-1:0]  tooth_idx,
    output logic                busy,
    output logic                cfg_err
);

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(CWG_MIN_PERIOD);
    localparam logic [TEETH_W-1:0]  T_ONE = TEETH_W'(1);
    localparam logic [TEETH_W:0]    T_TWO = (TEETH_W+1)'(2);

    cwg_state_t          r_state;
    logic [PERIOD_W-1:0] r_sh_period, r_act_period;
    logic [TEETH_W-1:0]  r_sh_total, r_sh_gap, r_act_total, r_act_gap;
    logic [TEETH_W-1:0]  r_tooth_idx, r_gap_cnt;
    logic                r_cfg_err, r_vr_out, r_tooth_edge, r_rev_sync, r_busy;

    logic                w_tmr_load, w_tmr_done;
    logic [PERIOD_W-1:0] w_tmr_val;
    logic                w_start, w_rev, w_to_low, w_to_gap, w_gap_next, w_stop;
    logic                w_sh_ok, w_wr_ok, w_can_run, w_last;
    logic [PERIOD_W-1:0] w_sh_half, w_act_half, w_period_clamped;
    logic [TEETH_W-1:0]  w_last_idx;

    assign w_sh_ok          = ({1'b0, r_sh_total} >= ({1'b0, r_sh_gap} + T_TWO));
    assign w_wr_ok          = ({1'b0, teeth_total_d} >= ({1'b0, gap_teeth_d} + T_TWO));
    assign w_can_run        = !r_cfg_err && w_sh_ok;
    assign w_last_idx       = r_act_total - r_act_gap - T_ONE;
    assign w_last           = (r_tooth_idx == w_last_idx);
    assign w_sh_half        = r_sh_period >> 1;
    assign w_act_half       = r_act_period >> 1;
    assign w_period_clamped = (period_d < P_MIN) ? P_MIN : period_d;

    // Next tooth always takes its timing from the shadow period, so a write landing
    // in the same cycle as a tooth start is only seen by the following tooth.
    always_comb begin
        w_start    = 1'b0;
        w_rev      = 1'b0;
        w_to_low   = 1'b0;
        w_to_gap   = 1'b0;
        w_gap_next = 1'b0;
        w_stop     = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        if (ena) begin
            unique case (r_state)
                CWG_IDLE: begin
                    if (w_can_run) begin
                        w_start = 1'b1;
                        w_rev   = 1'b1;
                    end
                end
                CWG_HIGH: w_to_low = w_tmr_done;
                CWG_LOW: begin
                    if (w_tmr_done) begin
                        if (!w_last)               w_start  = 1'b1;
                        else if (r_act_gap != '0)  w_to_gap = 1'b1;
                        else if (w_can_run)        {w_start, w_rev} = 2'b11;
                        else                       w_stop   = 1'b1;
                    end
                end
                CWG_GAP: begin
                    if (w_tmr_done) begin
                        if (r_gap_cnt != '0)  w_gap_next = 1'b1;
                        else if (w_can_run)   {w_start, w_rev} = 2'b11;
                        else                  w_stop = 1'b1;
                    end
                end
                default: w_stop = 1'b1;
            endcase
        end
        if (w_start) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = w_sh_half - P_ONE;
        end else if (w_to_low) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = r_act_period - w_act_half - P_ONE;
        end else if (w_to_gap || w_gap_next) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = r_act_period - P_ONE;
        end
    end

    crank_tooth_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= CWG_IDLE;
            r_sh_period  <= P_MIN;
            r_act_period <= P_MIN;
            r_sh_total   <= '0;
            r_sh_gap     <= '0;
            r_act_total  <= '0;
            r_act_gap    <= '0;
            r_tooth_idx  <= '0;
            r_gap_cnt    <= '0;
            r_cfg_err    <= 1'b0;
            r_vr_out     <= 1'b0;
            r_tooth_edge <= 1'b0;
            r_rev_sync   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (period_we) r_sh_period <= w_period_clamped;
            if (teeth_we) begin
                r_sh_total <= teeth_total_d;
                r_sh_gap   <= gap_teeth_d;
                r_cfg_err  <= !w_wr_ok;
            end
            r_tooth_edge <= 1'b0;
            r_rev_sync   <= 1'b0;
            if (!ena) begin
                r_state     <= CWG_IDLE;
                r_vr_out    <= 1'b0;
                r_busy      <= 1'b0;
                r_tooth_idx <= '0;
            end else if (w_start) begin
                r_state      <= CWG_HIGH;
                r_vr_out     <= 1'b1;
                r_tooth_edge <= 1'b1;
                r_busy       <= 1'b1;
                r_act_period <= r_sh_period;
                if (w_rev) begin
                    r_rev_sync  <= 1'b1;
                    r_tooth_idx <= '0;
                    r_act_total <= r_sh_total;
                    r_act_gap   <= r_sh_gap;
                end else begin
                    r_tooth_idx <= r_tooth_idx + T_ONE;
                end
            end else if (w_to_low) begin
                r_state  <= CWG_LOW;
                r_vr_out <= 1'b0;
            end else if (w_to_gap) begin
                r_state   <= CWG_GAP;
                r_gap_cnt <= r_act_gap - T_ONE;
            end else if (w_gap_next) begin
                r_gap_cnt <= r_gap_cnt - T_ONE;
            end else if (w_stop) begin
                r_state     <= CWG_IDLE;
                r_vr_out    <= 1'b0;
                r_busy      <= 1'b0;
                r_tooth_idx <= '0;
            end
        end
    end

    assign vr_out     = r_vr_out;
    assign tooth_edge = r_tooth_edge;
    assign rev_sync   = r_rev_sync;
    assign tooth_idx  = r_tooth_idx;
    assign busy       = r_busy;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Scoreboard bench for crank_wheel_gen: expected teeth are queued ahead, checked at each rising edge.
module tb_crank_wheel_gen;

    localparam int unsigned PW = 24;
    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          period_we;
    logic [PW-1:0] period_d;
    logic          teeth_we;
    logic [TW-1:0] teeth_total_d;
    logic [TW-1:0] gap_teeth_d;
    logic          vr_out;
    logic          tooth_edge;
    logic          rev_sync;
    logic [TW-1:0] tooth_idx;
    logic          busy;
    logic          cfg_err;

    always #5 clk = ~clk;

    crank_wheel_gen #(.PERIOD_W(PW), .TEETH_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .period_we     (period_we),
        .period_d      (period_d),
        .teeth_we      (teeth_we),
        .teeth_total_d (teeth_total_d),
        .gap_teeth_d   (gap_teeth_d),
        .vr_out        (vr_out),
        .tooth_edge    (tooth_edge),
        .rev_sync      (rev_sync),
        .tooth_idx     (tooth_idx),
        .busy          (busy),
        .cfg_err       (cfg_err)
    );

    // dt = clocks since previous rise (0: unchecked), hi = expected high width (0: unchecked)
    typedef struct {
        int unsigned dt;
        int unsigned idx;
        bit          rev;
        int unsigned hi;
    } edge_t;

    edge_t       q[$];
    edge_t       m_e;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;
    int unsigned hi_cnt = 0;
    int unsigned cur_hi = 0;
    bit          prev_vr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            prev_vr = 1'b0;
            hi_cnt  = 0;
            cur_hi  = 0;
        end else begin
            if (tooth_edge) begin
                chk("edge_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    m_e = q.pop_front();
                    if (m_e.dt != 0) chk("tooth_spacing", cyc - last_cyc, m_e.dt);
                    chk("tooth_idx", 32'(tooth_idx), m_e.idx);
                    chk("rev_sync", 32'(rev_sync), 32'(m_e.rev));
                    chk("vr_at_edge", 32'(vr_out), 32'd1);
                    cur_hi = m_e.hi;
                end
                last_cyc = cyc;
                hi_cnt   = 1;
            end else if (vr_out) begin
                hi_cnt++;
            end else if (prev_vr && cur_hi != 0) begin
                chk("high_width", hi_cnt, cur_hi);
            end
            prev_vr = vr_out;
        end
    end

    task automatic push(input int unsigned dt, input int unsigned idx, input bit rev, input int unsigned hi);
        edge_t e;
        e.dt  = dt;
        e.idx = idx;
        e.rev = rev;
        e.hi  = hi;
        q.push_back(e);
    endtask

    task automatic push_run(input int unsigned first, input int unsigned last,
                            input int unsigned dt, input int unsigned hi);
        for (int unsigned i = first; i <= last; i++) push(dt, i, 1'b0, hi);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int unsigned p);
        period_d  = PW'(p);
        period_we = 1'b1;
        tick();
        period_we = 1'b0;
    endtask

    task automatic set_teeth(input int unsigned t, input int unsigned g);
        teeth_total_d = TW'(t);
        gap_teeth_d   = TW'(g);
        teeth_we      = 1'b1;
        tick();
        teeth_we      = 1'b0;
    endtask

    task automatic drain(input string tag, input int unsigned limit);
        int unsigned n = 0;
        while (q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic wait_idx(input int unsigned k, input int unsigned limit);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tooth_edge && tooth_idx == TW'(k)) && n < limit);
        chk("wait_idx_reached", 32'(tooth_idx), k);
    endtask

    task automatic stop_run(input string tag);
        ena = 1'b0;
        tick();
        chk({tag, "_vr"}, 32'(vr_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idx"}, 32'(tooth_idx), 32'd0);
        chk({tag, "_edge"}, 32'(tooth_edge), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ena = 1'b0; period_we = 1'b0; period_d = '0;
        teeth_we = 1'b0; teeth_total_d = '0; gap_teeth_d = '0;
        #12;
        chk("rst_vr", 32'(vr_out), 32'd0);
        chk("rst_edge", 32'(tooth_edge), 32'd0);
        chk("rst_rev", 32'(rev_sync), 32'd0);
        chk("rst_idx", 32'(tooth_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        tick();

        // 60-2 at P=100
        set_period(100);
        set_teeth(60, 2);
        chk("s1_cfg_err", 32'(cfg_err), 32'd0);
        push(0, 0, 1'b1, 50);
        push_run(1, 57, 100, 50);
        push(300, 0, 1'b1, 0);
        ena = 1'b1;
        drain("s1_drain", 7000);
        stop_run("s1_stop");

        // P=101 with a period write in the middle of tooth 10
        set_period(101);
        push(0, 0, 1'b1, 50);
        push_run(1, 10, 101, 50);
        push(101, 11, 1'b0, 100);
        push(200, 12, 1'b0, 0);
        ena = 1'b1;
        wait_idx(10, 2000);
        repeat (5) tick();
        set_period(200);
        drain("s2_drain", 2000);
        stop_run("s2_stop");

        // 36-1 at P=40, switched to 60-2 mid-revolution
        set_period(40);
        set_teeth(36, 1);
        push(0, 0, 1'b1, 20);
        push_run(1, 34, 40, 20);
        push(80, 0, 1'b1, 20);
        push_run(1, 57, 40, 20);
        push(120, 0, 1'b1, 0);
        ena = 1'b1;
        wait_idx(10, 1000);
        tick();
        set_teeth(60, 2);
        drain("s3_drain", 6000);
        stop_run("s3_stop");

        // enable drop mid-HIGH of tooth 20, then re-enable
        set_period(100);
        push(0, 0, 1'b1, 50);
        push_run(1, 19, 100, 50);
        push(100, 20, 1'b0, 0);
        ena = 1'b1;
        drain("s5_drain", 3000);
        repeat (10) tick();
        stop_run("s5_drop");
        push(0, 0, 1'b1, 50);
        push(100, 1, 1'b0, 0);
        ena = 1'b1;
        drain("s5_reen_drain", 500);
        stop_run("s5_stop");

        // invalid teeth config holds IDLE; valid 4-0 write starts the wheel
        set_period(10);
        set_teeth(3, 2);
        chk("s4_cfg_err_set", 32'(cfg_err), 32'd1);
        ena = 1'b1;
        repeat (20) tick();
        chk("s4_busy_held", 32'(busy), 32'd0);
        chk("s4_vr_held", 32'(vr_out), 32'd0);
        chk("s4_cfg_err_sticky", 32'(cfg_err), 32'd1);
        push(0, 0, 1'b1, 5);
        for (int unsigned r = 0; r < 3; r++) begin
            push_run(1, 3, 10, 5);
            push(10, 0, 1'b1, 5);
        end
        push(10, 1, 1'b0, 5);
        set_teeth(4, 0);
        chk("s4_cfg_err_clr", 32'(cfg_err), 32'd0);
        drain("s6_drain", 500);

        // asynchronous reset in the LOW phase of tooth 1
        begin
            int unsigned n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (vr_out && n < 50);
        end
        chk("s6_busy_low", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("s6_arst_vr", 32'(vr_out), 32'd0);
        chk("s6_arst_busy", 32'(busy), 32'd0);
        chk("s6_arst_idx", 32'(tooth_idx), 32'd0);
        chk("s6_arst_rev", 32'(rev_sync), 32'd0);
        chk("s6_arst_cfg", 32'(cfg_err), 32'd0);
        ena = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) tick();
        chk("s6_post_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
